// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU issue stage.
package alu_pkg;

    localparam logic [4:0] OpAnds = 5'd1;
    localparam logic [4:0] OpEors = 5'd2;
    localparam logic [4:0] OpLsls = 5'd3;
    localparam logic [4:0] OpLsrs = 5'd4;
    localparam logic [4:0] OpAsrs = 5'd5;
    localparam logic [4:0] OpAdds = 5'd6;
    localparam logic [4:0] OpAdcs = 5'd7;
    localparam logic [4:0] OpSubs = 5'd8;
    localparam logic [4:0] OpSbcs = 5'd9;
    localparam logic [4:0] OpRsbs = 5'd10;
    localparam logic [4:0] OpRors = 5'd11;
    localparam logic [4:0] OpOrrs = 5'd12;
    localparam logic [4:0] OpMuls = 5'd13;
    localparam logic [4:0] OpBics = 5'd14;
    localparam logic [4:0] OpMvns = 5'd15;
    localparam logic [4:0] OpMovs = 5'd16;
    localparam logic [4:0] OpMov  = 5'd17;
    localparam logic [4:0] OpCmp  = 5'd18;
    localparam logic [4:0] OpNop  = 5'd19;

    localparam int unsigned FlagN = 0;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagC = 2;
    localparam int unsigned FlagV = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWb
    } state_e;

    function automatic logic op_legal(input logic [4:0] op);
        return (op >= OpAnds) && (op <= OpNop);
    endfunction

    // Opcodes 1..17 write a destination register and the flags.
    function automatic logic op_writes(input logic [4:0] op);
        return (op >= OpAnds) && (op <= OpMov);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one debug read port, one sync write port.
module alu_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data  = mem_q[ra_addr];
    assign rb_data  = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue stage: reads operands, drives an external registered ALU, writes back result and flags.
// Optional immediate second operand enabled by defining ALU_ISSUE_IMM_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rm,
    input  logic [7:0]        in_imm,
    input  logic              in_use_imm,
    output logic [4:0]        alu_instruction,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        apsr_flags,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [4:0]        op_q;
    logic [2:0]        rd_q;
    logic [4:0]        alu_instruction_q;
    logic [DATA_W-1:0] num1_q, num2_q, wb_data_q;
    logic [3:0]        apsr_q;
    logic              wb_valid_q, illegal_q;
    logic [2:0]        wb_rd_q;

    logic [DATA_W-1:0] rdata_a, rdata_b, operand_b;
    logic              rf_we;
    logic              unused_imm;

    assign rf_we = (state_q == StWb) && op_writes(op_q);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (3)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (in_rn),
        .ra_data  (rdata_a),
        .rb_addr  (in_rm),
        .rb_data  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (alu_result)
    );

    always_comb begin
        operand_b = rdata_b;
`ifdef ALU_ISSUE_IMM_EN
        if (in_use_imm) begin
            operand_b = {{(DATA_W-8){1'b0}}, in_imm};
        end
`endif
    end

    // Immediate inputs are intentionally dead when the feature is compiled out.
    assign unused_imm = ^{in_imm, in_use_imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIssue;
            // Illegal ops spend one cycle here and never reach writeback.
            StIssue: state_d = op_legal(op_q) ? StWb : StIdle;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign in_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q              <= '0;
            rd_q              <= '0;
            alu_instruction_q <= OpNop;
            num1_q            <= '0;
            num2_q            <= '0;
            apsr_q            <= '0;
            wb_valid_q        <= 1'b0;
            wb_rd_q           <= '0;
            wb_data_q         <= '0;
            illegal_q         <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q <= in_op;
                        rd_q <= in_rd;
                        if (op_legal(in_op)) begin
                            alu_instruction_q <= in_op;
                            num1_q            <= rdata_a;
                            num2_q            <= operand_b;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                StIssue: alu_instruction_q <= OpNop;
                StWb: begin
                    if (op_writes(op_q)) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= alu_result;
                        apsr_q     <= alu_flags;
                    end else if (op_q == OpCmp) begin
                        apsr_q <= alu_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_instruction = alu_instruction_q;
    assign alu_num1        = num1_q;
    assign alu_num2        = num2_q;
    assign apsr_flags      = apsr_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign illegal         = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; the bench itself acts as a registered ALU.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_op, alu_instruction;
    logic [2:0]  in_rd, in_rn, in_rm, wb_rd, dbg_addr;
    logic [7:0]  in_imm;
    logic        in_use_imm;
    logic [31:0] alu_num1, alu_num2, alu_result, wb_data, dbg_data;
    logic [3:0]  alu_flags, apsr_flags;
    logic        wb_valid, illegal;
    logic [31:0] ld_val;

    int checks = 0;
    int errors = 0;
    int w;

    alu_issue #(.DATA_W(32), .NREGS(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_rd           (in_rd),
        .in_rn           (in_rn),
        .in_rm           (in_rm),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .alu_instruction (alu_instruction),
        .alu_num1        (alu_num1),
        .alu_num2        (alu_num2),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags),
        .apsr_flags      (apsr_flags),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .illegal         (illegal),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    // Returns {V,C,Z,N, result}; MOVS returns ld_val so the bench can preload registers.
    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a, b, ld);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            OpAnds: r = a & b;
            OpEors: r = a ^ b;
            OpOrrs: r = a | b;
            OpAdds: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OpCmp: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OpMovs:  r = ld;
            default: r = '0;
        endcase
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    always @(posedge clk) begin
        {alu_flags, alu_result} <= alu_model(alu_instruction, alu_num1, alu_num2, ld_val);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an op and holds it until accepted; returns the number of edges waited.
    task automatic send(input logic [4:0] op, input logic [2:0] rd, rn, rm, output int waited);
        bit acc;
        in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_valid = 1'b1;
        waited = 0;
        acc = 1'b0;
        while (waited < 20) begin
            acc = in_ready;
            @(posedge clk);
            waited++;
            if (acc) break;
            #1;
        end
        #1 in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $error("FAIL accept_timeout op %0d observed no accept expected accept", op);
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [2:0] rd, rn, rm);
        int n;
        send(op, rd, rn, rm, n);
        tick();
        tick();
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1 check(tag, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0;
        in_imm = '0; in_use_imm = 1'b0; dbg_addr = '0; ld_val = '0;
        #23;
        check("rst_instr", alu_instruction, 32'd19);
        check("rst_num1", alu_num1, 32'd0);
        check("rst_num2", alu_num2, 32'd0);
        check("rst_apsr", apsr_flags, 32'd0);
        check("rst_wb", {wb_valid, illegal, wb_rd}, 32'd0);
        check("rst_wbdata", wb_data, 32'd0);
        check_reg("rst_r0", 3'd0, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_ready", in_ready, 32'd1);

        // Basic ADDS 5 + 7
        ld_val = 32'd5;  run_op(OpMovs, 3'd0, 3'd0, 3'd0);
        check("mov_r0", wb_data, 32'd5);
        ld_val = 32'd7;  run_op(OpMovs, 3'd1, 3'd0, 3'd0);
        send(OpAdds, 3'd2, 3'd0, 3'd1, w);
        check("adds_latency", w, 32'd1);
        check("adds_instr", alu_instruction, {27'd0, OpAdds});
        check("adds_num1", alu_num1, 32'd5);
        check("adds_num2", alu_num2, 32'd7);
        check("adds_busy", in_ready, 32'd0);
        tick();
        check("adds_e1_nop", alu_instruction, 32'd19);
        check("adds_e1_wb", wb_valid, 32'd0);
        check("adds_e1_busy", in_ready, 32'd0);
        tick();
        check("adds_wbv", wb_valid, 32'd1);
        check("adds_wbrd", wb_rd, 32'd2);
        check("adds_wbdata", wb_data, 32'd12);
        check("adds_apsr", apsr_flags, 32'd0);
        check("adds_ready", in_ready, 32'd1);
        check_reg("adds_r2", 3'd2, 32'd12);
        tick();
        check("adds_wbv_pulse", wb_valid, 32'd0);

        // Overflowing ADDS then CMP
        ld_val = 32'hFFFF_FFFF; run_op(OpMovs, 3'd0, 3'd0, 3'd0);
        check("mov_neg_apsr", apsr_flags, 32'h1);
        run_op(OpMovs, 3'd1, 3'd0, 3'd0);
        run_op(OpAdds, 3'd3, 3'd0, 3'd1);
        check("addc_wbdata", wb_data, 32'hFFFF_FFFE);
        check("addc_apsr", apsr_flags, 32'h5);
        run_op(OpCmp, 3'd0, 3'd3, 3'd0);
        check("cmp_wbv", wb_valid, 32'd0);
        check("cmp_apsr", apsr_flags, 32'h1);
        check_reg("cmp_r3", 3'd3, 32'hFFFF_FFFE);
        check_reg("cmp_r0", 3'd0, 32'hFFFF_FFFF);

        // Back-to-back dependent ops: ANDS r4 = r0 & r2, EORS r6 = r4 ^ r1
        send(OpAnds, 3'd4, 3'd0, 3'd2, w);
        send(OpEors, 3'd6, 3'd4, 3'd1, w);
        check("b2b_latency", w, 32'd3);
        check("b2b_num1", alu_num1, 32'h0000_000C);
        check("b2b_instr", alu_instruction, {27'd0, OpEors});
        tick();
        tick();
        check("b2b_wbdata", wb_data, 32'hFFFF_FFF3);
        check("b2b_wbrd", wb_rd, 32'd6);
        check("b2b_apsr", apsr_flags, 32'h1);
        check_reg("b2b_r4", 3'd4, 32'h0000_000C);

        // Illegal opcodes
        send(5'd0, 3'd7, 3'd0, 3'd1, w);
        check("ill0_pulse", illegal, 32'd1);
        check("ill0_instr", alu_instruction, 32'd19);
        check("ill0_busy", in_ready, 32'd0);
        tick();
        check("ill0_clear", illegal, 32'd0);
        check("ill0_ready", in_ready, 32'd1);
        send(5'd25, 3'd7, 3'd0, 3'd1, w);
        check("ill25_pulse", illegal, 32'd1);
        check("ill25_instr", alu_instruction, 32'd19);
        tick();
        check("ill25_clear", illegal, 32'd0);
        check("ill25_wb", wb_valid, 32'd0);
        tick();
        check("ill25_wb2", wb_valid, 32'd0);
        check("ill_apsr", apsr_flags, 32'h1);
        check_reg("ill_r7", 3'd7, 32'd0);

        // NOP still occupies three cycles
        send(OpNop, 3'd7, 3'd0, 3'd1, w);
        check("nop_instr", alu_instruction, 32'd19);
        tick();
        check("nop_busy_wb", in_ready, 32'd0);
        tick();
        check("nop_wbv", wb_valid, 32'd0);
        check("nop_apsr", apsr_flags, 32'h1);
        check("nop_ill", illegal, 32'd0);
        check_reg("nop_r7", 3'd7, 32'd0);

        // Reset while an ADDS is in flight
        send(OpAdds, 3'd5, 3'd0, 3'd1, w);
        tick();
        rst_n = 1'b0;
        #1 check("midrst_ready", in_ready, 32'd1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("midrst_rel_ready", in_ready, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_wbv", wb_valid, 32'd0);
        end
        check("midrst_apsr", apsr_flags, 32'd0);
        check_reg("midrst_r5", 3'd5, 32'd0);
        check_reg("midrst_r0", 3'd0, 32'd0);

        // Immediate second operand (only honoured when the feature is built in)
        ld_val = 32'h55; run_op(OpMovs, 3'd1, 3'd0, 3'd0);
        in_use_imm = 1'b1; in_imm = 8'h80;
        send(OpOrrs, 3'd7, 3'd0, 3'd1, w);
        in_use_imm = 1'b0; in_imm = 8'h00;
`ifdef ALU_ISSUE_IMM_EN
        check("imm_num2", alu_num2, 32'h0000_0080);
`else
        check("imm_num2", alu_num2, 32'h0000_0055);
`endif
        tick();
        tick();
`ifdef ALU_ISSUE_IMM_EN
        check("imm_wbdata", wb_data, 32'h0000_0080);
`else
        check("imm_wbdata", wb_data, 32'h0000_0055);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
